// File: rtl/ssd_scan_capture_if.sv
// Seven-segment display bus seen by the scan capture block, plus its decoded results.
// master drives the display lines; slave is the capture block.
interface ssd_scan_capture_if;
  logic        enable;
  logic [6:0]  ssdCathode;
  logic [7:0]  ssdAnode;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        decode_err;
  logic        anode_err;

  modport master (
    output enable, ssdCathode, ssdAnode,
    input  digits, digit_valid, frame_done, decode_err, anode_err
  );

  modport slave (
    input  enable, ssdCathode, ssdAnode,
    output digits, digit_valid, frame_done, decode_err, anode_err
  );
endinterface

// File: rtl/ssd_scan_capture.sv
// Reads back a multiplexed active-low seven-segment bus: waits for each digit slot
// to settle, decodes the cathode pattern to a nibble and tracks frame completion.
module ssd_scan_capture #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  DIGIT_MASK    = 8'hFF
) (
  input logic               clk,
  input logic               reset,
  ssd_scan_capture_if.slave bus
);

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned AN_W       = 8;
  localparam int unsigned CAT_W      = 7;
  localparam int unsigned PAIR_W     = 1 + AN_W + CAT_W;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned IDX_W      = 3;
  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);
  localparam logic [CAT_W-1:0] BLANK  = 7'h7F;

  logic [PAIR_W-1:0]           pair_d, pair_q;
  logic                        vld_q;
  logic [CNT_W-1:0]            cnt_d, cnt_q;
  logic                        changed;
  logic                        sample;
  logic [AN_W-1:0]             an_sel;
  logic [CAT_W-1:0]            cat_q;
  logic                        one_hot;
  logic                        multi;
  logic [NIB_W:0]              dec;
  logic [IDX_W-1:0]            idx;
  logic [NUM_DIGITS*NIB_W-1:0] digits_d, digits_q;
  logic [NUM_DIGITS-1:0]       valid_d, valid_q;
  logic [NUM_DIGITS-1:0]       seen_d, seen_q, seen_new;
  logic                        frame_d, frame_q;
  logic                        dec_err_d, dec_err_q;
  logic                        an_err_d, an_err_q;

  // Cathode pattern to {hit, nibble}; hit=0 for anything outside the hex table.
  function automatic logic [NIB_W:0] hex_decode(input logic [CAT_W-1:0] cat);
    case (cat)
      7'h40:   hex_decode = 5'h10;
      7'h79:   hex_decode = 5'h11;
      7'h24:   hex_decode = 5'h12;
      7'h30:   hex_decode = 5'h13;
      7'h19:   hex_decode = 5'h14;
      7'h12:   hex_decode = 5'h15;
      7'h02:   hex_decode = 5'h16;
      7'h78:   hex_decode = 5'h17;
      7'h00:   hex_decode = 5'h18;
      7'h10:   hex_decode = 5'h19;
      7'h08:   hex_decode = 5'h1A;
      7'h03:   hex_decode = 5'h1B;
      7'h46:   hex_decode = 5'h1C;
      7'h21:   hex_decode = 5'h1D;
      7'h06:   hex_decode = 5'h1E;
      7'h0E:   hex_decode = 5'h1F;
      default: hex_decode = 5'h00;
    endcase
  endfunction

  // Enable rides along with the pair so that re-enabling restarts the settle period.
  assign pair_d  = {bus.enable, bus.ssdAnode, bus.ssdCathode};
  assign changed = !vld_q || (pair_d != pair_q);

  assign an_sel  = ~pair_q[PAIR_W-2:CAT_W];
  assign cat_q   = pair_q[CAT_W-1:0];
  assign one_hot = (an_sel != '0) && ((an_sel & (an_sel - AN_W'(1))) == '0);
  assign multi   = (an_sel != '0) && !one_hot;
  assign dec     = hex_decode(cat_q);

  // Stability counter; the sample fires only on the step that reaches SETTLE.
  always_comb begin : settle_count
    cnt_d  = cnt_q;
    sample = 1'b0;
    if (!bus.enable || changed) begin
      cnt_d = '0;
    end else if (cnt_q != SETTLE) begin
      cnt_d  = cnt_q + CNT_W'(1);
      sample = (cnt_q + CNT_W'(1)) == SETTLE;
    end
  end

  always_comb begin : sample_decode
    digits_d  = digits_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    seen_new  = seen_q;
    frame_d   = 1'b0;
    dec_err_d = 1'b0;
    an_err_d  = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (an_sel[i]) idx = IDX_W'(i);
    end
    if (sample) begin
      if (multi) begin
        an_err_d = 1'b1;
      end else if (one_hot) begin
        seen_new = seen_q | an_sel;
        seen_d   = seen_new;
        if (dec[NIB_W]) begin
          digits_d[{idx, 2'b00} +: NIB_W] = dec[NIB_W-1:0];
          valid_d[idx]                    = 1'b1;
        end else begin
          valid_d[idx] = 1'b0;
          dec_err_d    = (cat_q != BLANK);
        end
        // A decode error owns the pulse slot; the frame completes on a later sample.
        if (!dec_err_d && ((seen_new & DIGIT_MASK) == DIGIT_MASK)) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pair_q    <= '0;
      vld_q     <= 1'b0;
      cnt_q     <= '0;
      digits_q  <= '0;
      valid_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      dec_err_q <= 1'b0;
      an_err_q  <= 1'b0;
    end else begin
      pair_q    <= pair_d;
      vld_q     <= 1'b1;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      dec_err_q <= dec_err_d;
      an_err_q  <= an_err_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_q;
  assign bus.decode_err  = dec_err_q;
  assign bus.anode_err   = an_err_q;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Table-driven bench for ssd_scan_capture: full-frame and single-digit instances
// share stimulus; expected results are queued at drive time and checked on arrival.
module tb_ssd_scan_capture;

  localparam int unsigned S = 4;

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  an;
    logic [6:0]  cat;
    int          hold;
    logic        smp;
    logic [31:0] dig;
    logic [7:0]  vld;
    logic        fa;
    logic        fb;
    logic        de;
    logic        ae;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] dig;
    logic [7:0]  vld;
    logic        fa;
    logic        fb;
    logic        de;
    logic        ae;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ssd_scan_capture_if bus_a ();
  ssd_scan_capture_if bus_b ();

  ssd_scan_capture #(.SETTLE_CYCLES(S), .DIGIT_MASK(8'hFF)) u_full (
    .clk(clk), .reset(reset), .bus(bus_a));
  ssd_scan_capture #(.SETTLE_CYCLES(S), .DIGIT_MASK(8'h01)) u_one (
    .clk(clk), .reset(reset), .bus(bus_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, req);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic en, input logic [7:0] an,
                              input logic [6:0] cat, input int hold, input logic smp,
                              input logic [31:0] dig, input logic [7:0] vld,
                              input logic fa, input logic fb, input logic de, input logic ae);
    vec_t v;
    v.rst = rst; v.en = en; v.an = an; v.cat = cat; v.hold = hold; v.smp = smp;
    v.dig = dig; v.vld = vld; v.fa = fa; v.fb = fb; v.de = de; v.ae = ae;
    return v;
  endfunction

  task automatic set_inputs(input logic en, input logic [7:0] an, input logic [6:0] cat);
    bus_a.enable = en; bus_a.ssdAnode = an; bus_a.ssdCathode = cat;
    bus_b.enable = en; bus_b.ssdAnode = an; bus_b.ssdCathode = cat;
  endtask

  // Five reset edges with random inputs, the last one already holding the next pair.
  task automatic do_reset(input vec_t v);
    chk("queue_drained_before_reset", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      reset = 1'b0;
      if (i == 4) set_inputs(v.en, v.an, v.cat);
      else set_inputs(1'($urandom), 8'($urandom), 7'($urandom));
      @(posedge clk);
    end
    #1;
    chk("rst_digits_a", bus_a.digits, 32'd0);
    chk("rst_valid_a", {24'd0, bus_a.digit_valid}, 32'd0);
    chk("rst_pulses_a", {29'd0, bus_a.frame_done, bus_a.decode_err, bus_a.anode_err}, 32'd0);
    chk("rst_digits_b", bus_b.digits, 32'd0);
    chk("rst_valid_b", {24'd0, bus_b.digit_valid}, 32'd0);
  endtask

  // Called just after a rising edge; drives the vector and queues its expectation.
  task automatic apply(input vec_t v);
    exp_t e;
    if (v.rst) do_reset(v);
    #1;
    reset = 1'b1;
    set_inputs(v.en, v.an, v.cat);
    e.dig = v.dig;
    e.vld = v.vld;
    if (v.smp) begin
      e.due = cyc + int'(S) + 1;
      e.fa = v.fa; e.fb = v.fb; e.de = v.de; e.ae = v.ae;
    end else begin
      e.due = cyc + v.hold;
      e.fa = 1'b0; e.fb = 1'b0; e.de = 1'b0; e.ae = 1'b0;
    end
    sb.push_back(e);
    repeat (v.hold) @(posedge clk);
  endtask

  // Scoreboard: exact-cycle compare on due entries, quiet pulses everywhere else.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL stale_entry: due %0d, now %0d", sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      chk("digits_a", bus_a.digits, mon_e.dig);
      chk("valid_a", {24'd0, bus_a.digit_valid}, {24'd0, mon_e.vld});
      chk("frame_a", {31'd0, bus_a.frame_done}, {31'd0, mon_e.fa});
      chk("frame_b", {31'd0, bus_b.frame_done}, {31'd0, mon_e.fb});
      chk("decode_err", {30'd0, bus_a.decode_err, bus_b.decode_err}, {30'd0, mon_e.de, mon_e.de});
      chk("anode_err", {30'd0, bus_a.anode_err, bus_b.anode_err}, {30'd0, mon_e.ae, mon_e.ae});
    end else begin
      chk("idle_pulses_a", {29'd0, bus_a.frame_done, bus_a.decode_err, bus_a.anode_err}, 32'd0);
      chk("idle_pulses_b", {29'd0, bus_b.frame_done, bus_b.decode_err, bus_b.anode_err}, 32'd0);
    end
  end

  initial begin
    int guard;
    set_inputs(1'b0, 8'hFF, 7'h7F);
    // rst en  anode  cath  hold smp digits        valid  fa fb de ae
    tbl.push_back(mk(1, 1, 8'hFF, 7'h7F,  8, 0, 32'h00000000, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFE, 7'h24, 10, 1, 32'h00000002, 8'h01, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFE, 7'h79, 10, 1, 32'h00000001, 8'h01, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFD, 7'h24,  5, 1, 32'h00000021, 8'h03, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFB, 7'h30, 10, 1, 32'h00000321, 8'h07, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hF7, 7'h19, 10, 1, 32'h00004321, 8'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hEF, 7'h12, 10, 1, 32'h00054321, 8'h1F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hDF, 7'h02, 10, 1, 32'h00654321, 8'h3F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hBF, 7'h78, 10, 1, 32'h07654321, 8'h7F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h7F, 7'h00, 10, 1, 32'h87654321, 8'hFF, 1, 0, 0, 0));
    // glitch held exactly S cycles must not be sampled
    tbl.push_back(mk(0, 1, 8'hFE, 7'h24, 10, 1, 32'h87654322, 8'hFF, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFE, 7'h40,  4, 0, 32'h87654322, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFE, 7'h79, 10, 1, 32'h87654321, 8'hFF, 0, 1, 0, 0));
    // error cases and blank digit
    tbl.push_back(mk(0, 1, 8'hFC, 7'h24, 10, 1, 32'h87654321, 8'hFF, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'hFE, 7'h55, 10, 1, 32'h87654321, 8'hFE, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFE, 7'h7F, 10, 1, 32'h87654321, 8'hFE, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFE, 7'h79, 10, 1, 32'h87654321, 8'hFF, 0, 1, 0, 0));
    // enable dropped two cycles into a stable interval
    tbl.push_back(mk(0, 1, 8'hFD, 7'h30,  2, 0, 32'h87654321, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'hFD, 7'h30,  6, 0, 32'h87654321, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFD, 7'h30, 10, 1, 32'h87654331, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFB, 7'h02, 10, 1, 32'h87654631, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hF7, 7'h78, 10, 1, 32'h87657631, 8'hFF, 0, 0, 0, 0));
    // reset mid-frame: digits 4..7 alone must not complete a frame
    tbl.push_back(mk(1, 1, 8'hEF, 7'h12, 10, 1, 32'h00050000, 8'h10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hDF, 7'h02, 10, 1, 32'h00650000, 8'h30, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hBF, 7'h78, 10, 1, 32'h07650000, 8'h70, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h7F, 7'h00, 10, 1, 32'h87650000, 8'hF0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFE, 7'h79, 10, 1, 32'h87650001, 8'hF1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFD, 7'h24, 10, 1, 32'h87650021, 8'hF3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFB, 7'h30, 10, 1, 32'h87650321, 8'hF7, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hF7, 7'h19, 10, 1, 32'h87654321, 8'hFF, 1, 0, 0, 0));

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    guard = 0;
    @(negedge clk);
    while (sb.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries still pending", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_capture.md
Name: ssd_scan_capture

Overview:
- Monitor/reader for the multiplexed seven-segment display bus on the Nexys4 DDR board.
- Samples the active-low anode and cathode lines driven by the display drivers and waits for each digit slot to settle.
- Decodes each cathode pattern back to a hex nibble and assembles an 8-digit value.
- Used in self-checking benches and in on-chip loopback checks of the display path.

Parameters:
- SETTLE_CYCLES, 4: consecutive clk cycles an anode/cathode pair must stay unchanged before it is sampled. Legal range 1..255.
- DIGIT_MASK, 8'hFF: digit slots that must be sampled before frame_done fires. 8'h01 is used for single-digit displays.

Ports:
- clk, in, 1: system clock (100 MHz).
- reset, in, 1: synchronous, active-low reset.
- enable, in, 1: capture enable.
- ssdCathode, in, 7: segments {g,f,e,d,c,b,a}, active-low.
- ssdAnode, in, 8: digit selects, active-low. Bit i is digit i.
- digits, out, 32: captured nibbles. digits[4i+3:4i] is digit i.
- digit_valid, out, 8: bit i is set when digit i holds a valid decoded nibble.
- frame_done, out, 1: one-cycle pulse when every DIGIT_MASK slot has been sampled.
- decode_err, out, 1: one-cycle pulse on an unrecognised cathode pattern.
- anode_err, out, 1: one-cycle pulse when more than one anode is low.

Behaviour:
- Reset: reset==0 at a rising edge clears all internal state. All outputs go to 0: digits=32'h0, digit_valid=8'h00, frame_done=0, decode_err=0, anode_err=0, seen mask=0, stability counter=0.
- Input stage: {ssdAnode, ssdCathode} is registered once into pair_q. No synchroniser is needed because the source is on the same clk.
- Stability counter:
  - Clears to 0 on any cycle where pair_q differs from its previous value.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - A sample event occurs exactly once per stable interval, in the cycle the counter reaches SETTLE_CYCLES.
- Latency: a pair held constant on the inputs from edge n has its effect on digits, digit_valid and the pulse outputs visible after edge n+SETTLE_CYCLES+1. A pair that changes before then is never sampled (glitch rejection).
- Sample decode, by anode state:
  - ssdAnode == 8'hFF: no digit selected. Ignored: no update, no pulse.
  - Exactly one anode bit i low:
    - Cathode pattern in the hex table: write the nibble to digit i, set digit_valid[i], set seen[i].
    - Cathode == 7'h7F (blank): nibble unchanged, clear digit_valid[i], set seen[i], no error.
    - Any other pattern: nibble unchanged, clear digit_valid[i], set seen[i], pulse decode_err.
  - Two or more anodes low: pulse anode_err. No writes, seen unchanged.
- Hex table (cathode value to nibble):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
- Frame tracking:
  - When (seen & DIGIT_MASK) == DIGIT_MASK after a sample, frame_done pulses on the same edge as the digit update and seen clears to 0.
  - The completing sample counts toward the finished frame, not the next one.
  - Digits outside DIGIT_MASK are still captured but never gate frame_done.
- enable == 0: the stability counter is held at 0 and no samples occur. digits, digit_valid and seen hold their values; pulses stay 0. On re-enable the settle period restarts from 0.
- Reset mid-interval: all state is cleared. A pair already stable must settle for the full SETTLE_CYCLES again.
- Pulses never stretch. At most one pulse output is asserted in any cycle.

Test Plan:
1. Reset and hold: reset=0 for 5 cycles, inputs random → all outputs 0. Release reset with ssdAnode=8'hFF → outputs stay 0 indefinitely.
2. Single digit, SETTLE_CYCLES=4, DIGIT_MASK=8'h01: ssdAnode=8'hFE, ssdCathode=7'h24 held → digits[3:0]=2, digit_valid=8'h01 and a one-cycle frame_done, all 5 edges after the inputs are applied. Holding longer produces no further pulse.
3. Full scan: drive digits 0..7 with patterns for 1,2,3,4,5,6,7,8, each held 10 cycles → digits=32'h87654321, digit_valid=8'hFF, exactly one frame_done on digit 7's sample.
4. Glitch rejection: hold ssdCathode=7'h40 on anode 0 for 3 cycles, then 7'h79 held → only nibble 1 is captured, no decode_err.
5. Errors:
   - ssdAnode=8'hFC → anode_err pulse, digits unchanged.
   - ssdAnode=8'hFE with ssdCathode=7'h55 → decode_err pulse, digit_valid[0] cleared, nibble retained.
   - ssdCathode=7'h7F → digit_valid[0] cleared, no pulse.
6. Enable and reset mid-operation:
   - Drop enable two cycles into a stable interval for 6 cycles, then raise it → sample occurs SETTLE_CYCLES+1 edges after re-enable.
   - Assert reset mid-frame → seen clears, and frame_done requires all masked digits again.
